// File: rtl/stream_fifo.sv
// stream_fifo: single-clock valid/ready FIFO with almost-full flag.
// Optional `level` occupancy port is enabled by defining STREAM_FIFO_LEVEL_EN.
`default_nettype none

module stream_fifo #(
  parameter int DATA_WIDTH        = 8,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          almost_full
`ifdef STREAM_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]    level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full;
  logic                  push;
  logic                  pop;

  assign full      = (count_q == CW'(DEPTH));
  // Reset gating keeps the producer stalled for every cycle rst is high.
  assign in_ready  = !rst && !full;
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign almost_full = (count_q >= CW'(ALMOST_FULL_LEVEL));

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

`ifdef STREAM_FIFO_LEVEL_EN
  assign level = count_q;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

`default_nettype wire

// File: doc/stream_fifo.md
# stream_fifo

Parametrised synchronous stream FIFO with valid/ready handshakes on both sides, configurable data width and depth, and an almost-full flag. It buffers a single data stream between a producer and a consumer in the same clock domain. It is the first DUT-style block in the Verilog examples and is driven by parameterised `TEST_SUITE` benches that sweep its generics from the run script.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of each data word; must be ≥ 1.
- `DEPTH`, 16, number of storage entries; must be a power of two ≥ 2.
- `ALMOST_FULL_LEVEL`, `DEPTH-2`, occupancy at or above which `almost_full` asserts; legal range 1..`DEPTH`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_ready`  out  1  FIFO accepts a word this cycle.
- `in_data`  in  `DATA_WIDTH`  write data.
- `out_valid`  out  1  `out_data` holds the oldest stored word.
- `out_ready`  in  1  consumer takes the word this cycle.
- `out_data`  out  `DATA_WIDTH`  read data.
- `almost_full`  out  1  occupancy ≥ `ALMOST_FULL_LEVEL`.
- `level`  out  `$clog2(DEPTH+1)`  current occupancy; present only with `STREAM_FIFO_LEVEL_EN`.

## Operation
- Push: `in_valid && in_ready` at a rising edge writes `in_data` at the write pointer and advances the pointer.
- Pop: `out_valid && out_ready` at a rising edge advances the read pointer.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally from `DEPTH-1` to 0.
- Occupancy counter is `$clog2(DEPTH+1)` bits wide:
  - +1 on push only, −1 on pop only, unchanged on both or neither.
- `in_ready = !full`, where `full` means count == `DEPTH`.
- `out_valid = (count != 0)`.
- `out_data` is the memory word at the read pointer; its value is undefined when `out_valid` is 0.
- Full: `in_ready` is 0. A simultaneous pop does not enable a push in the same cycle; there is no pass-through when full.
- Empty: `out_valid` is 0. A push into an empty FIFO is not visible at the output in the same cycle.
- Simultaneous push and pop with 0 < count < `DEPTH`: both complete and count is unchanged.
- `in_valid` while `in_ready` is 0: no effect, the data is dropped silently. Holding the word is the producer's responsibility.
- Data order is strictly FIFO. Memory contents are never cleared.

## Timing
- Reset values: count 0, both pointers 0, `out_valid` 0, `almost_full` 0, `level` 0.
- `in_ready` is 0 while `rst` is high and 1 in the first cycle after `rst` deasserts.
- `rst` asserted mid-operation empties the FIFO at that edge. Any push or pop in the same cycle is ignored.
- Write-to-read latency is 1 cycle: a word pushed at edge N gives `out_valid` = 1 and valid `out_data` after edge N.
- `in_ready`, `out_valid`, `almost_full` and `level` are decoded from registered state only; none depends combinationally on `in_valid` or `out_ready`.
- Sustained throughput is one word per cycle when 0 < count < `DEPTH`.

## Configuration
- `STREAM_FIFO_LEVEL_EN` defined:
  - `level` port exists and equals the occupancy counter.
- `STREAM_FIFO_LEVEL_EN` undefined:
  - `level` port is absent.
  - All other behaviour is identical.
  - The counter remains internal, because `almost_full`, `in_ready` and `out_valid` depend on it.

## Test plan
- Reset, then idle 5 cycles: `in_ready` 1, `out_valid` 0, `almost_full` 0, `level` 0.
- Push 0x01..0x03 on consecutive cycles with `out_ready` 0, then pop all: `out_valid` rises 1 cycle after the first push; outputs are 0x01, 0x02, 0x03 in order; `level` goes 1, 2, 3 and back to 0.
- With `DEPTH`=16, push 16 words with no pops:
  - `almost_full` rises when `level` reaches 14.
  - `in_ready` is 0 at `level` 16.
  - A 17th `in_valid` of 0xAA is dropped; popping 16 words never returns 0xAA.
- When full, assert `in_valid` and `out_ready` together: the pop completes, the push does not, and `level` goes 16 → 15. The next cycle both complete and `level` stays at 15.
- Stream 40 words with `in_valid` and `out_ready` held at 1 at `DEPTH`=4: the pointers wrap 10 times, output equals input in order, and `level` stays at 1 after the first cycle.
- Assert `rst` for 1 cycle at `level` 7: the next cycle `level` is 0, `out_valid` is 0, and the next pushed word 0x5A is the first word popped.
